pwl_sample_fifo: RTL and testbench

PWL_SAMPLE_FIFO -- requirements
Module: pwl_sample_fifo

---
 rtl/pwl_sample_fifo_if.sv | 47 ++++
 rtl/pwl_sample_fifo.sv | 144 ++++++++++++++
 tb/tb_pwl_sample_fifo.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwl_sample_fifo_if.sv
// pwl_sample_fifo_if
//   Bundles the sampler's handshake and data signals. The slave modport
//   belongs to pwl_sample_fifo; the master modport belongs to whoever
//   drives the PWL input and consumes FIFO entries.
//
//   en     : sampling enable (to sampler)
//   in     : PWL signal a + b*(t - t0), in volts, V/s and seconds (to sampler)
//   ready  : consumer accepts the head entry (to sampler)
//   dout   : signed code of the FIFO head (from sampler)
//   valid  : FIFO non-empty (from sampler)
//   level  : FIFO occupancy (from sampler)
//   ovf    : sticky overflow flag (from sampler)
//   tstamp : capture time in seconds of the head entry (from sampler),
//            present only when PWL_SAMPLE_FIFO_TSTAMP_EN is defined
interface pwl_sample_fifo_if #(
  parameter int NBIT  = 8,
  parameter int DEPTH = 4
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int LW = $clog2(DEPTH + 1);

  typedef struct {
    real a;
    real b;
    real t0;
  } pwl_t;

  logic                   en;
  pwl_t                   in;
  logic                   ready;
  logic signed [NBIT-1:0] dout;
  logic                   valid;
  logic [LW-1:0]          level;
  logic                   ovf;

`ifdef PWL_SAMPLE_FIFO_TSTAMP_EN
  real                    tstamp;

  modport master (output en, in, ready, input dout, valid, level, ovf, tstamp);
  modport slave  (input en, in, ready, output dout, valid, level, ovf, tstamp);
`else
  modport master (output en, in, ready, input dout, valid, level, ovf);
  modport slave  (input en, in, ready, output dout, valid, level, ovf);
`endif
endinterface

// File: rtl/pwl_sample_fifo.sv
// pwl_sample_fifo
//   Samples a piecewise-linear input every DECIM enabled clocks, quantizes
//   scale*v to a saturated signed NBIT code (lsb volts per code) and queues
//   the codes in a DEPTH-entry FIFO drained through a valid/ready handshake.
//   Overflowing captures are dropped and latch a sticky ovf flag.
//
//   Ports:
//     clk : the only clock, rising edge
//     rst : synchronous active-high reset
//     bus : pwl_sample_fifo_if.slave (en, in, ready -> dout, valid, level, ovf)
//
//   Optional feature: define PWL_SAMPLE_FIFO_TSTAMP_EN to store the capture
//   time (seconds) with every entry and present the head's time on bus.tstamp.
//
//   Simulation time is read with $realtime in this module's 1 ns time unit and
//   converted to seconds before evaluating the PWL expression.
module pwl_sample_fifo #(
  parameter real scale = 1.0,
  parameter real lsb   = 1e-3,
  parameter int  NBIT  = 8,
  parameter int  DEPTH = 4,
  parameter int  DECIM = 1
) (
  input logic              clk,
  input logic              rst,
  pwl_sample_fifo_if.slave bus
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int  PW      = $clog2(DEPTH);
  localparam int  LW      = $clog2(DEPTH + 1);
  localparam int  DW      = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int  CMAX    = (1 << (NBIT - 1)) - 1;
  localparam int  CMIN    = -(1 << (NBIT - 1));
  localparam real TUNIT_S = 1.0e-9;

  // Round half away from zero, clamping before the integer conversion so
  // large voltages cannot overflow $rtoi.
  function automatic logic signed [NBIT-1:0] quantize(input real v);
    real x;
    int  r;
    x = v / lsb;
    if (x >= real'(CMAX))      r = CMAX;
    else if (x <= real'(CMIN)) r = CMIN;
    else if (x >= 0.0)         r = $rtoi(x + 0.5);
    else                       r = -$rtoi(0.5 - x);
    return NBIT'(r);
  endfunction

  function automatic logic signed [NBIT-1:0] sample_code(input real a, input real b,
                                                         input real t0, input real t_s);
    return quantize(scale * (a + b * (t_s - t0)));
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic signed [NBIT-1:0] dout_q;
  logic signed [NBIT-1:0] mem_q [DEPTH];
  logic                   cap, pop, push;

  // Next-state control: capture/pop decisions, pointers, occupancy, overflow
  always_comb begin
    cap  = bus.en && (dcnt_q == '0);
    pop  = (level_q != '0) && bus.ready;
    // A full FIFO still accepts the capture when the head leaves on the same edge.
    push = cap && ((level_q != LW'(DEPTH)) || pop);

    dcnt_d = dcnt_q;
    if (bus.en) dcnt_d = (dcnt_q == DW'(DECIM - 1)) ? '0 : dcnt_q + 1'b1;

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    ovf_d = ovf_q | (cap & ~push);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      dcnt_q   <= dcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage and head register. The new head is the freshly captured code
  // when it lands in the slot the read pointer moves to (FIFO was empty, or
  // held one entry that is popped on this edge); otherwise it is read from
  // the array. dout is left alone while the FIFO goes empty.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= sample_code(bus.in.a, bus.in.b, bus.in.t0, $realtime * TUNIT_S);
    if (rst)
      dout_q <= '0;
    else if (level_d != '0)
      dout_q <= (push && (wr_ptr_q == rd_ptr_d))
                ? sample_code(bus.in.a, bus.in.b, bus.in.t0, $realtime * TUNIT_S)
                : mem_q[rd_ptr_d];
  end

`ifdef PWL_SAMPLE_FIFO_TSTAMP_EN
  real ts_q [DEPTH];
  real tstamp_q;

  // Timestamp storage follows exactly the same write/head rules as the codes
  always_ff @(posedge clk) begin
    if (!rst && push)
      ts_q[wr_ptr_q] <= $realtime * TUNIT_S;
    if (rst)
      tstamp_q <= 0.0;
    else if (level_d != '0)
      tstamp_q <= (push && (wr_ptr_q == rd_ptr_d)) ? $realtime * TUNIT_S : ts_q[rd_ptr_d];
  end

  assign bus.tstamp = tstamp_q;
`else
  // Codes only; no per-entry timestamps are kept.
`endif

  assign bus.dout  = dout_q;
  assign bus.valid = (level_q != '0);
  assign bus.level = level_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_pwl_sample_fifo.sv
// Bench for pwl_sample_fifo: one DECIM=1 instance (scale 1.0) and one DECIM=4
// instance (scale 0.5), both DEPTH=4, NBIT=8, lsb=1 mV, 10 ns clock.
// The reference model keeps each FIFO as a queue of integer codes computed
// directly from the PWL formula.
module tb_pwl_sample_fifo;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int  NBIT  = 8;
  localparam int  DEPTH = 4;
  localparam real SC_M  = 1.0;
  localparam real SC_D  = 0.5;
  localparam real LSB   = 1.0e-3;
  localparam int  CMAX  = 127;
  localparam int  CMIN  = -128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwl_sample_fifo_if #(.NBIT(NBIT), .DEPTH(DEPTH)) bus   ();
  pwl_sample_fifo_if #(.NBIT(NBIT), .DEPTH(DEPTH)) bus_d ();

  pwl_sample_fifo #(.scale(SC_M), .lsb(LSB), .NBIT(NBIT), .DEPTH(DEPTH), .DECIM(1))
    dut   (.clk(clk), .rst(rst), .bus(bus));
  pwl_sample_fifo #(.scale(SC_D), .lsb(LSB), .NBIT(NBIT), .DEPTH(DEPTH), .DECIM(4))
    dut_d (.clk(clk), .rst(rst), .bus(bus_d));

  int n_cmp = 0;
  int n_bad = 0;

  int mq[$];
  bit m_ovf;
  int dq[$];
  bit d_ovf;
  int d_ens;

  function automatic int ref_code(input real sc, input real a, input real b,
                                  input real t0, input real t_s);
    real x, r;
    x = (sc * (a + b * (t_s - t0))) / LSB;
    r = (x >= 0.0) ? $floor(x + 0.5) : $ceil(x - 0.5);
    if (r > real'(CMAX)) return CMAX;
    if (r < real'(CMIN)) return CMIN;
    return int'(r);
  endfunction

  function automatic real rnd_a();
    return (real'(int'($urandom_range(300)) - 150) + 0.3) * 1.0e-3;
  endfunction

  task automatic set_in(input real a, input real b, input real t0);
    bus.in.a   = a;  bus.in.b   = b;  bus.in.t0   = t0;
    bus_d.in.a = a;  bus_d.in.b = b;  bus_d.in.t0 = t0;
  endtask

  // Advance one rising edge, update both models with the inputs present at
  // that edge, then return 1 ns later for sampling and new stimulus.
  task automatic tick();
    real t_s;
    bit  pop;
    @(posedge clk);
    t_s = $realtime * 1.0e-9;
    if (rst) begin
      mq.delete(); m_ovf = 0;
      dq.delete(); d_ovf = 0; d_ens = 0;
    end else begin
      pop = (mq.size() > 0) && bus.ready;
      if (pop) mq.delete(0);
      if (bus.en) begin
        if (mq.size() < DEPTH) mq.push_back(ref_code(SC_M, bus.in.a, bus.in.b, bus.in.t0, t_s));
        else m_ovf = 1;
      end
      pop = (dq.size() > 0) && bus_d.ready;
      if (pop) dq.delete(0);
      if (bus_d.en) begin
        if (d_ens % 4 == 0) begin
          if (dq.size() < DEPTH) dq.push_back(ref_code(SC_D, bus_d.in.a, bus_d.in.b, bus_d.in.t0, t_s));
          else d_ovf = 1;
        end
        d_ens++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.ready = 1'b1; bus_d.en = 1'b1; bus_d.ready = 1'b0;
    set_in(0.05, 0.0, 0.0);
    tick(); tick();
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_cmp++; if (int'(bus.level) !== 0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (int'(bus.dout) !== 0) begin n_bad++; $display("FAIL reset_dout: got %0d want 0", bus.dout); end
    n_cmp++; if (int'(bus_d.level) !== 0) begin n_bad++; $display("FAIL reset_level_d: got %0d want 0", bus_d.level); end
    bus.en = 1'b0; bus.ready = 1'b0; bus_d.en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_constant();
    do_reset();
    set_in(0.1, 0.0, 0.0);
    bus.ready = 1'b1; bus.en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL const_valid[%0d]: got %b want 1", k, bus.valid); end
      n_cmp++; if (int'(bus.dout) !== 100) begin n_bad++; $display("FAIL const_dout[%0d]: got %0d want 100", k, bus.dout); end
      n_cmp++; if (int'(bus.level) !== 1) begin n_bad++; $display("FAIL const_level[%0d]: got %0d want 1", k, bus.level); end
    end
    bus.en = 1'b0;
    tick();
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL const_drain_valid: got %b want 0", bus.valid); end
  endtask

  task automatic test_ramp();
    int exp_c;
    for (int dir = 0; dir < 2; dir++) begin
      do_reset();
      bus.ready = 1'b1; bus.en = 1'b1;
      // t0 is the next rising edge, 9 ns from now
      set_in(0.0, (dir == 0) ? 1.0e6 : -1.0e6, ($realtime + 9.0) * 1.0e-9);
      for (int k = 0; k < 16; k++) begin
        tick();
        exp_c = (dir == 0) ? ((10 * k > CMAX) ? CMAX : 10 * k)
                           : ((-10 * k < CMIN) ? CMIN : -10 * k);
        n_cmp++; if (int'(bus.dout) !== exp_c) begin n_bad++; $display("FAIL ramp%0d_dout[%0d]: got %0d want %0d", dir, k, bus.dout, exp_c); end
      end
    end
    bus.en = 1'b0; bus.ready = 1'b0;
  endtask

  task automatic test_decimation();
    int  dexp[4];
    real t0v;
    do_reset();
    bus.en = 1'b0; bus.ready = 1'b0;
    bus_d.ready = 1'b0; bus_d.en = 1'b1;
    t0v = ($realtime + 9.0) * 1.0e-9;
    set_in(-0.05, 1.0e6, t0v);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k % 4 == 0) dexp[k / 4] = ref_code(SC_D, -0.05, 1.0e6, t0v, ($realtime - 1.0) * 1.0e-9);
      n_cmp++; if (int'(bus_d.level) !== k / 4 + 1) begin n_bad++; $display("FAIL decim_level[%0d]: got %0d want %0d", k, bus_d.level, k / 4 + 1); end
    end
    n_cmp++; if (bus_d.ovf !== 1'b0) begin n_bad++; $display("FAIL decim_ovf: got %b want 0", bus_d.ovf); end
    bus_d.en = 1'b0; bus_d.ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (int'(bus_d.dout) !== dexp[j]) begin n_bad++; $display("FAIL decim_dout[%0d]: got %0d want %0d", j, bus_d.dout, dexp[j]); end
      tick();
    end
    n_cmp++; if (bus_d.valid !== 1'b0) begin n_bad++; $display("FAIL decim_drain_valid: got %b want 0", bus_d.valid); end
    bus_d.ready = 1'b0;
  endtask

  task automatic test_overflow();
    int  exp_c[6];
    real a;
    do_reset();
    bus.ready = 1'b0; bus.en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a = rnd_a();
      set_in(a, 0.0, 0.0);
      exp_c[c] = ref_code(SC_M, a, 0.0, 0.0, 0.0);
      tick();
    end
    n_cmp++; if (int'(bus.level) !== 4) begin n_bad++; $display("FAIL ovf_level: got %0d want 4", bus.level); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
    bus.en = 1'b0; bus.ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (int'(bus.dout) !== exp_c[j]) begin n_bad++; $display("FAIL ovf_drain_dout[%0d]: got %0d want %0d", j, bus.dout, exp_c[j]); end
      tick();
    end
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drain_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
    bus.ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    int  exp_c[7];
    real a;
    do_reset();
    bus.ready = 1'b0; bus.en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) bus.ready = 1'b1;
      a = rnd_a();
      set_in(a, 0.0, 0.0);
      exp_c[c] = ref_code(SC_M, a, 0.0, 0.0, 0.0);
      tick();
      if (c >= 3) begin
        n_cmp++; if (int'(bus.level) !== 4) begin n_bad++; $display("FAIL full_pp_level[%0d]: got %0d want 4", c, bus.level); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL full_pp_ovf[%0d]: got %b want 0", c, bus.ovf); end
        n_cmp++; if (int'(bus.dout) !== exp_c[c - 3]) begin n_bad++; $display("FAIL full_pp_dout[%0d]: got %0d want %0d", c, bus.dout, exp_c[c - 3]); end
      end
    end
    bus.en = 1'b0; bus.ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    real a;
    do_reset();
    bus.ready = 1'b0; bus.en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_in(rnd_a(), 0.0, 0.0);
      tick();
    end
    bus.en = 1'b0; bus.ready = 1'b1;
    tick();
    n_cmp++; if (int'(bus.level) !== 3) begin n_bad++; $display("FAIL mid_pre_level: got %0d want 3", bus.level); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL mid_pre_ovf: got %b want 1", bus.ovf); end
    rst = 1'b1; bus.en = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (int'(bus.level) !== 0) begin n_bad++; $display("FAIL mid_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL mid_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (int'(bus.dout) !== 0) begin n_bad++; $display("FAIL mid_dout: got %0d want 0", bus.dout); end
    a = rnd_a();
    set_in(a, 0.0, 0.0);
    tick();
    n_cmp++; if (int'(bus.level) !== 1) begin n_bad++; $display("FAIL mid_cap_level: got %0d want 1", bus.level); end
    n_cmp++; if (int'(bus.dout) !== ref_code(SC_M, a, 0.0, 0.0, 0.0)) begin n_bad++; $display("FAIL mid_cap_dout: got %0d want %0d", bus.dout, ref_code(SC_M, a, 0.0, 0.0, 0.0)); end
    bus.en = 1'b0; bus.ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst         = ($urandom_range(59) == 0);
      bus.en      = ($urandom_range(3) != 0);
      bus.ready   = ($urandom_range(1) != 0);
      bus_d.en    = ($urandom_range(3) != 0);
      bus_d.ready = ($urandom_range(2) == 0);
      set_in(rnd_a(), real'(int'($urandom_range(2000)) - 1000) * 1.0e3,
             ($realtime + real'(int'($urandom_range(100)) - 50)) * 1.0e-9);
      tick();
      n_cmp++; if (int'(bus.level) !== mq.size()) begin n_bad++; $display("FAIL rnd_level[%0d]: got %0d want %0d", k, bus.level, mq.size()); end
      n_cmp++; if (bus.valid !== (mq.size() > 0)) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, bus.valid, mq.size() > 0); end
      n_cmp++; if (bus.ovf !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", k, bus.ovf, m_ovf); end
      if (mq.size() > 0) begin
        n_cmp++; if (int'(bus.dout) !== mq[0]) begin n_bad++; $display("FAIL rnd_dout[%0d]: got %0d want %0d", k, bus.dout, mq[0]); end
      end
      n_cmp++; if (int'(bus_d.level) !== dq.size()) begin n_bad++; $display("FAIL rnd_level_d[%0d]: got %0d want %0d", k, bus_d.level, dq.size()); end
      n_cmp++; if (bus_d.ovf !== d_ovf) begin n_bad++; $display("FAIL rnd_ovf_d[%0d]: got %b want %b", k, bus_d.ovf, d_ovf); end
      if (dq.size() > 0) begin
        n_cmp++; if (int'(bus_d.dout) !== dq[0]) begin n_bad++; $display("FAIL rnd_dout_d[%0d]: got %0d want %0d", k, bus_d.dout, dq[0]); end
      end
    end
    rst = 1'b0;
    bus.en = 1'b0; bus.ready = 1'b0; bus_d.en = 1'b0; bus_d.ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_decimation();
    test_overflow();
    test_full_pushpop();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
